// File: rtl/tx_os_scheduler.sv
// TX source scheduler: muxes the lane between the LPIF FIFO and the
// ordered-set generator, splitting only at packet boundaries.
module tx_os_scheduler #(
  parameter int          SKP_INTERVAL = 1180,
  parameter logic [2:0]  SKP_OS_TYPE  = 3'd3,
  parameter int          CNT_W        = 12
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       link_up,
  input  logic       ltssm_os_req,
  input  logic [2:0] ltssm_os_type,
  output logic       ltssm_os_ack,
  input  logic       fifo_valid,
  input  logic       fifo_pkt_end,
  output logic       fifo_hold,
  output logic       os_start,
  output logic [2:0] os_type,
  input  logic       os_busy,
  input  logic       os_finish,
  output logic       mux_sel,
  output logic       skp_pending,
  output logic [7:0] skp_sent_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    OS_LAUNCH,
    OS_RUN
  } state_t;

  localparam logic [CNT_W-1:0] WRAP = CNT_W'(SKP_INTERVAL - 1);

  state_t           state, state_n;
  logic [2:0]       type_n;
  logic             src_skp, src_skp_n;
  logic             in_pkt, in_pkt_n;
  logic             ack_n;
  logic [7:0]       cnt_n;
  logic             clr_pend;
  logic [CNT_W-1:0] skp_timer;
  logic             wrap;
  logic             req_eff;
  logic             os_need;
  logic             consumed;

  // Request is masked during the ack cycle so one request sends one OS.
  assign req_eff  = ltssm_os_req & ~ltssm_os_ack;
  assign os_need  = ltssm_os_req | skp_pending;
  assign mux_sel  = (state != DATA);
  assign os_start = (state == OS_LAUNCH);
  assign fifo_hold = (state != DATA) |
                     (~in_pkt & os_need);
  assign consumed = fifo_valid & ~fifo_hold;
  assign wrap     = link_up & (skp_timer == WRAP);

  // Next-state, launch bookkeeping and packet tracking.
  always_comb begin
    state_n   = state;
    type_n    = os_type;
    src_skp_n = src_skp;
    in_pkt_n  = in_pkt;
    ack_n     = 1'b0;
    cnt_n     = skp_sent_cnt;
    clr_pend  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_eff & ~os_busy) begin
          state_n   = OS_LAUNCH;
          type_n    = ltssm_os_type;
          src_skp_n = 1'b0;
        end else if (skp_pending & link_up & ~os_busy) begin
          state_n   = OS_LAUNCH;
          type_n    = SKP_OS_TYPE;
          src_skp_n = 1'b1;
        end else if (link_up) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (consumed)
          in_pkt_n = ~fifo_pkt_end;
        if (~link_up) begin
          state_n  = IDLE;
          in_pkt_n = 1'b0;
        end else if (~in_pkt_n & os_need) begin
          state_n = IDLE;
        end
      end
      OS_LAUNCH: begin
        state_n  = OS_RUN;
        clr_pend = src_skp;
      end
      OS_RUN: begin
        if (os_finish) begin
          state_n = IDLE;
          if (src_skp)
            cnt_n = skp_sent_cnt + 8'd1;
          else
            ack_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state        <= IDLE;
      os_type      <= 3'd0;
      src_skp      <= 1'b0;
      in_pkt       <= 1'b0;
      ltssm_os_ack <= 1'b0;
      skp_sent_cnt <= 8'd0;
    end else begin
      state        <= state_n;
      os_type      <= type_n;
      src_skp      <= src_skp_n;
      in_pkt       <= in_pkt_n;
      ltssm_os_ack <= ack_n;
      skp_sent_cnt <= cnt_n;
    end
  end

  // SKP timer; a wrap wins over a same-cycle launch clear.
  always_ff @(posedge pclk) begin
    if (reset | ~link_up) begin
      skp_timer   <= '0;
      skp_pending <= 1'b0;
    end else if (wrap) begin
      skp_timer   <= '0;
      skp_pending <= 1'b1;
    end else begin
      skp_timer <= skp_timer + 1'b1;
      if (clr_pend)
        skp_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Directed bench for tx_os_scheduler with a launch/ack scoreboard
// and a simple auto-responding OS generator model.
module tb_tx_os_scheduler;

  logic       pclk = 1'b0;
  logic       reset;
  logic       link_up;
  logic       ltssm_os_req;
  logic [2:0] ltssm_os_type;
  logic       ltssm_os_ack;
  logic       fifo_valid;
  logic       fifo_pkt_end;
  logic       fifo_hold;
  logic       os_start;
  logic [2:0] os_type;
  logic       os_busy;
  logic       os_finish;
  logic       mux_sel;
  logic       skp_pending;
  logic [7:0] skp_sent_cnt;

  logic busy_man = 1'b0;
  logic busy_gen = 1'b0;
  logic fin_man = 1'b0;
  logic fin_gen = 1'b0;
  logic auto_gen = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_os[$];
  logic [2:0] exp_ack[$];

  assign os_busy   = busy_man | busy_gen;
  assign os_finish = fin_man | fin_gen;

  always #5 pclk = ~pclk;

  tx_os_scheduler #(
    .SKP_INTERVAL(16),
    .SKP_OS_TYPE(3'd3),
    .CNT_W(12)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .link_up(link_up),
    .ltssm_os_req(ltssm_os_req),
    .ltssm_os_type(ltssm_os_type),
    .ltssm_os_ack(ltssm_os_ack),
    .fifo_valid(fifo_valid),
    .fifo_pkt_end(fifo_pkt_end),
    .fifo_hold(fifo_hold),
    .os_start(os_start),
    .os_type(os_type),
    .os_busy(os_busy),
    .os_finish(os_finish),
    .mux_sel(mux_sel),
    .skp_pending(skp_pending),
    .skp_sent_cnt(skp_sent_cnt)
  );

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    link_up = 1'b0;
    ltssm_os_req = 1'b0;
    ltssm_os_type = 3'd0;
    fifo_valid = 1'b0;
    fifo_pkt_end = 1'b0;
    busy_man = 1'b0;
    fin_man = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every launch and every ack must be expected.
  always @(negedge pclk) begin
    if (!reset) begin
      if (os_start) begin
        if (exp_os.size() == 0)
          check("unexpected_os_start", 8'(os_type), 8'hff);
        else
          check("os_start_type", 8'(os_type), 8'(exp_os.pop_front()));
      end
      if (ltssm_os_ack) begin
        if (exp_ack.size() == 0)
          check("unexpected_ack", 8'(os_type), 8'hff);
        else
          check("ack_type", 8'(os_type), 8'(exp_ack.pop_front()));
      end
    end
  end

  // OS generator model: busy from launch, finish pulse three edges later.
  initial begin
    forever begin
      @(negedge pclk);
      if (auto_gen && os_start) begin
        busy_gen = 1'b1;
        repeat (3) @(posedge pclk);
        #1 fin_gen = 1'b1;
        @(posedge pclk);
        #1 fin_gen = 1'b0;
        busy_gen = 1'b0;
      end
    end
  end

  initial begin
    bit seen;
    do_reset();
    reset = 1'b1;
    @(negedge pclk);
    check("rst_mux_sel", 8'(mux_sel), 8'd1);
    check("rst_fifo_hold", 8'(fifo_hold), 8'd1);
    check("rst_os_start", 8'(os_start), 8'd0);
    check("rst_os_type", 8'(os_type), 8'd0);
    check("rst_ack", 8'(ltssm_os_ack), 8'd0);
    check("rst_skp_pending", 8'(skp_pending), 8'd0);
    check("rst_skp_cnt", skp_sent_cnt, 8'd0);
    tick();
    reset = 1'b0;

    // LTSSM OS with link down, manual finish.
    ltssm_os_req = 1'b1;
    ltssm_os_type = 3'd1;
    exp_os.push_back(3'd1);
    exp_ack.push_back(3'd1);
    tick();
    check("ltssm_os_start", 8'(os_start), 8'd1);
    tick();
    check("ltssm_start_once", 8'(os_start), 8'd0);
    repeat (5) tick();
    check("ltssm_no_early_ack", 8'(ltssm_os_ack), 8'd0);
    fin_man = 1'b1;
    tick();
    fin_man = 1'b0;
    check("ltssm_ack", 8'(ltssm_os_ack), 8'd1);
    ltssm_os_req = 1'b0;
    tick();
    check("ltssm_ack_once", 8'(ltssm_os_ack), 8'd0);
    repeat (4) tick();
    check("ltssm_no_relaunch", 8'(mux_sel), 8'd1);

    // SKP cadence with empty FIFO.
    do_reset();
    auto_gen = 1'b1;
    link_up = 1'b1;
    repeat (3) exp_os.push_back(3'd3);
    repeat (15) tick();
    check("skp_not_yet", 8'(skp_pending), 8'd0);
    tick();
    check("skp_pending_16", 8'(skp_pending), 8'd1);
    repeat (10) tick();
    check("skp_mux_back_data", 8'(mux_sel), 8'd0);
    check("skp_cleared", 8'(skp_pending), 8'd0);
    check("skp_cnt_1", skp_sent_cnt, 8'd1);
    repeat (32) tick();
    check("skp_cnt_3", skp_sent_cnt, 8'd3);
    check("skp_queue_drained", 8'(exp_os.size()), 8'd0);

    // Packet boundary: SKP due mid-packet waits for END.
    do_reset();
    link_up = 1'b1;
    exp_os.push_back(3'd3);
    repeat (13) tick();
    for (int i = 0; i < 6; i++) begin
      fifo_valid = 1'b1;
      fifo_pkt_end = (i == 5);
      @(negedge pclk);
      check("pkt_word_consumed", 8'(fifo_hold), 8'd0);
      check("pkt_mux_fifo", 8'(mux_sel), 8'd0);
      tick();
      if (i == 2)
        check("pkt_skp_due", 8'(skp_pending), 8'd1);
    end
    fifo_pkt_end = 1'b0;
    check("pkt_hold_after_end", 8'(fifo_hold), 8'd1);
    check("pkt_mux_after_end", 8'(mux_sel), 8'd1);
    check("pkt_no_start_yet", 8'(os_start), 8'd0);
    tick();
    check("pkt_os_start", 8'(os_start), 8'd1);
    fifo_valid = 1'b0;
    repeat (8) tick();
    check("pkt_skp_cnt", skp_sent_cnt, 8'd1);

    // Priority with generator busy.
    do_reset();
    link_up = 1'b1;
    busy_man = 1'b1;
    exp_os.push_back(3'd2);
    exp_os.push_back(3'd3);
    exp_ack.push_back(3'd2);
    repeat (16) tick();
    ltssm_os_req = 1'b1;
    ltssm_os_type = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_no_start", 8'(os_start), 8'd0);
    end
    busy_man = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = ltssm_os_ack;
    end
    check("prio_ack_seen", 8'(seen), 8'd1);
    ltssm_os_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = (skp_sent_cnt == 8'd1);
    end
    check("prio_skp_done", 8'(seen), 8'd1);
    check("prio_queue_drained", 8'(exp_os.size()), 8'd0);

    // Link drop mid-packet.
    do_reset();
    link_up = 1'b1;
    repeat (13) tick();
    for (int i = 0; i < 3; i++) begin
      fifo_valid = 1'b1;
      tick();
    end
    check("drop_pending_before", 8'(skp_pending), 8'd1);
    check("drop_in_pkt_before", 8'(dut.in_pkt), 8'd1);
    link_up = 1'b0;
    tick();
    check("drop_mux_sel", 8'(mux_sel), 8'd1);
    check("drop_fifo_hold", 8'(fifo_hold), 8'd1);
    check("drop_skp_pending", 8'(skp_pending), 8'd0);
    check("drop_in_pkt", 8'(dut.in_pkt), 8'd0);
    fifo_valid = 1'b0;

    // Reset while an LTSSM OS is running.
    do_reset();
    auto_gen = 1'b0;
    ltssm_os_req = 1'b1;
    ltssm_os_type = 3'd5;
    exp_os.push_back(3'd5);
    repeat (3) tick();
    ltssm_os_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstos_mux_sel", 8'(mux_sel), 8'd1);
    check("rstos_fifo_hold", 8'(fifo_hold), 8'd1);
    check("rstos_os_start", 8'(os_start), 8'd0);
    check("rstos_os_type", 8'(os_type), 8'd0);
    check("rstos_ack", 8'(ltssm_os_ack), 8'd0);
    fin_man = 1'b1;
    tick();
    fin_man = 1'b0;
    tick();
    check("rstos_no_ack", 8'(ltssm_os_ack), 8'd0);
    check("rstos_cnt", skp_sent_cnt, 8'd0);
    repeat (3) tick();
    check("final_os_queue", 8'(exp_os.size()), 8'd0);
    check("final_ack_queue", 8'(exp_ack.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
